bcd_count_seg_mux: RTL



---
 rtl/seg_pkg.sv | 24 ++
 rtl/seven_seg_decode.sv | 29 ++
 rtl/bcd_count_seg_mux.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the BCD counter / seven-segment display slice:
// segment patterns in gfe_dcba order, the blank pattern and the BCD digit type.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Loaded nibbles above 9 are not legal BCD; they saturate to 9.
    function automatic bcd_t clamp_bcd(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to gfe_dcba segment decoder with a blank override.
module seven_seg_decode
    import seg_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_count_seg_mux.sv
// Multi-digit BCD up/down counter with load and wrap flag, driving a
// time-multiplexed seven-segment display from a single clock domain.
module bcd_count_seg_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 10,
    parameter int SCAN_DIV       = 4,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int BLANK_LZ       = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
    output logic [4*NUM_DIGITS-1:0] COUNT,
    output logic                    WRAP,
    output logic [6:0]              SEG_C,
    output logic [NUM_DIGITS-1:0]   SEG_SEL
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]         presc_q;
    logic                  tick;
    logic [NUM_DIGITS-1:0] dig_max;
    logic [NUM_DIGITS-1:0] dig_min;
    logic                  all_max;
    logic                  all_min;

    // ---- prescaler: one count step every TICK_DIV enabled cycles ----
    assign tick = EN && (presc_q == PRESC_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
        end else if (LOAD || tick) begin
            presc_q <= '0;
        end else if (EN) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // ---- BCD digit array: a digit steps when every lower digit is at its limit ----
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [NUM_DIGITS-1:0] LOWER = NUM_DIGITS'((1 << i) - 1);

        bcd_t digit_q;
        bcd_t digit_nxt;
        logic step;

        assign dig_max[i] = (digit_q == 4'd9);
        assign dig_min[i] = (digit_q == 4'd0);
        assign step       = UP ? &(dig_max | ~LOWER) : &(dig_min | ~LOWER);

        always_comb begin
            digit_nxt = digit_q;
            if (step) begin
                if (UP) begin
                    digit_nxt = dig_max[i] ? 4'd0 : digit_q + 4'd1;
                end else begin
                    digit_nxt = dig_min[i] ? 4'd9 : digit_q - 4'd1;
                end
            end
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                digit_q <= '0;
            end else if (LOAD) begin
                digit_q <= clamp_bcd(LOAD_VAL[4*i +: 4]);
            end else if (tick) begin
                digit_q <= digit_nxt;
            end
        end

        assign COUNT[4*i +: 4] = digit_q;
    end

    assign all_max = &dig_max;
    assign all_min = &dig_min;

    // A tick discarded by LOAD must not report a wrap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= tick && !LOAD && (UP ? all_max : all_min);
        end
    end

    // ---- scan divider and display position ----
    logic [SW-1:0] scan_div_q;
    logic [IW-1:0] scan_idx_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_div_q <= '0;
            scan_idx_q <= '0;
        end else if (scan_div_q == SCAN_LAST) begin
            scan_div_q <= '0;
            scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
        end else begin
            scan_div_q <= scan_div_q + SW'(1);
        end
    end

    // ---- blanking: lz[i] is set when digits i..NUM_DIGITS-1 are all zero ----
    logic [NUM_DIGITS-1:0] lz;
    bcd_t                  cur_digit;
    logic                  cur_blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] sel_hot;

    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run & dig_min[i];
            lz[i] = run;
        end
    end

    assign cur_digit = COUNT[4*scan_idx_q +: 4];
    assign cur_blank = (BLANK_LZ != 0) && (scan_idx_q != '0) && lz[scan_idx_q];
    assign sel_hot   = NUM_DIGITS'(1) << scan_idx_q;

    seven_seg_decode u_decode (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_raw)
    );

    // ---- output register: held inactive for the first edge after reset ----
    logic disp_vld_p0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            disp_vld_p0 <= 1'b0;
            SEG_C       <= SEG_BLANK ^ SEG_POL;
            SEG_SEL     <= SEL_OFF;
        end else begin
            disp_vld_p0 <= 1'b1;
            if (disp_vld_p0) begin
                SEG_C   <= seg_raw ^ SEG_POL;
                SEG_SEL <= sel_hot ^ SEL_OFF;
            end
        end
    end

endmodule
